loop_player_ctrl: RTL
=====================

LOOP_PLAYER_CTRL -- requirements
Module: loop_player_ctrl

Interface
REQ-001 SHALL have parameter BEAT_W, default 12, beat index width.
REQ-002 SHALL have parameter LEN, default 4095, song length in beats; legal range LOOP_NOTES*BPN <= LEN <= 2**BEAT_W.
REQ-003 SHALL have parameter BPN, default 4, beats per note; legal values are powers of two >= 2.
REQ-004 SHALL have parameter LOOP_NOTES, default 4, loop window length in notes; legal range >= 1.
REQ-005 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: tick  in  1  beat-advance strobe; play  in  1  level, 1=play/0=pause; loop_en  in  1  level loop request.
REQ-007 SHALL have ports: stop  in  1  pulse; seek_fwd  in  1  pulse; seek_bwd  in  1  pulse; rev  in  1  level, reverse direction.
REQ-008 SHALL have ports: ibeat  out  BEAT_W  current beat; loop_active  out  1  state==LOOP; at_end  out  1  wrap pulse.

Function
REQ-009 SHALL implement states IDLE, PLAY, PAUSE, LOOP.
REQ-010 SHALL make these transitions: IDLE->PLAY when play=1; PLAY->PAUSE when play=0; PLAY->LOOP when loop_en=1; LOOP->PLAY when loop_en=0; LOOP->PAUSE when play=0, discarding the window; PAUSE->PLAY when play=1.
REQ-011 SHALL, on stop=1 in any state, go to IDLE with ibeat=0 on the next edge; stop SHALL take priority over seek, and seek SHALL take priority over tick.
REQ-012 SHALL, on PLAY->LOOP entry, latch hi = min(ibeat - ibeat%BPN + BPN-1, LEN-1) and lo = max(ibeat - ibeat%BPN - (LOOP_NOTES-1)*BPN, 0); ibeat is unchanged on entry.
REQ-013 SHALL advance ibeat only when tick=1 in PLAY or LOOP; ibeat SHALL hold in IDLE and PAUSE.
REQ-014 SHALL, for a forward tick in PLAY, set ibeat to ibeat+1, or to 0 when ibeat==LEN-1, in which case at_end=1 for exactly that one cycle.
REQ-015 SHALL, for a forward tick in LOOP, set ibeat to lo when ibeat==hi and to ibeat+1 otherwise; at_end SHALL stay 0.
REQ-016 SHALL, on seek_fwd in PLAY or PAUSE, set ibeat to the next note start; if that value is >= LEN, ibeat SHALL become 0 with no at_end.
REQ-017 SHALL, on seek_bwd in PLAY or PAUSE, set ibeat to the current note start minus BPN, clamped at 0.
REQ-018 SHALL ignore seeks in IDLE and LOOP; simultaneous seek_fwd and seek_bwd SHALL be ignored.
REQ-019 SHALL compute all arithmetic at BEAT_W+1 bits so that no intermediate value wraps silently.
REQ-020 SHALL drive all outputs from registers, with a one-cycle latency from input to output.

Reset
REQ-021 SHALL, while reset=1, force state=IDLE, ibeat=0, lo=0, hi=0, loop_active=0, at_end=0, asynchronously.
REQ-022 SHALL, on reset mid-LOOP, discard the window; a new loop SHALL latch a fresh window.

Configuration
REQ-023 SHALL support reverse play when macro LOOP_PLAYER_REVERSE_EN is defined: with rev=1, a tick in PLAY decrements ibeat, and ibeat 0 wraps to LEN-1 with at_end=1 for one cycle.
REQ-024 SHALL, with LOOP_PLAYER_REVERSE_EN defined and rev=1, on a tick in LOOP set ibeat to hi when ibeat==lo and to ibeat-1 otherwise.
REQ-025 SHALL, without LOOP_PLAYER_REVERSE_EN, ignore rev; the port remains present and all ticks are forward.

Verification
REQ-026 SHALL cover: reset, play=1, 10 ticks -> ibeat=10, loop_active=0, at_end=0 throughout.
REQ-027 SHALL cover: at ibeat=50, loop_en=1 -> lo=36, hi=51; ticks give the sequence 50,51,36,37 and loop_active=1.
REQ-028 SHALL cover: at ibeat=5, loop_en=1 -> window 0..7; tick at 7 -> ibeat=0; then loop_en=0 and 3 ticks -> ibeat=3.
REQ-029 SHALL cover: ibeat=4094, tick -> ibeat=0 with at_end high exactly 1 cycle; seek_fwd at 4093 -> 0 with at_end=0.
REQ-030 SHALL cover: seek_bwd at 6 -> 0; seek_bwd at 2 -> 0; stop, seek_fwd and tick in the same cycle -> IDLE, ibeat=0.
REQ-031 SHALL cover, with LOOP_PLAYER_REVERSE_EN and rev=1: tick at 0 -> 4094 with at_end=1; in LOOP window 36..51, tick at 36 -> 51.

Source files
------------

// File: rtl/loop_player_ctrl.sv
// loop_player_ctrl: beat-position controller with play/pause, note seeking and a
// note-aligned loop window. Define LOOP_PLAYER_REVERSE_EN to enable reverse play via rev.
module loop_player_ctrl #(
  parameter int BEAT_W     = 12,
  parameter int LEN        = 4095,
  parameter int BPN        = 4,
  parameter int LOOP_NOTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              play,
  input  logic              loop_en,
  input  logic              stop,
  input  logic              seek_fwd,
  input  logic              seek_bwd,
  input  logic              rev,
  output logic [BEAT_W-1:0] ibeat,
  output logic              loop_active,
  output logic              at_end
);

  localparam int W1 = BEAT_W + 1;
  localparam logic [W1-1:0] ZERO_W = W1'(0);
  localparam logic [W1-1:0] ONE_W  = W1'(1);
  localparam logic [W1-1:0] LEN_W  = W1'(LEN);
  localparam logic [W1-1:0] LAST_W = W1'(LEN - 1);
  localparam logic [W1-1:0] BPN_W  = W1'(BPN);
  localparam logic [W1-1:0] SPAN_W = W1'((LOOP_NOTES - 1) * BPN);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2, LOOP = 2'd3} state_t;

  state_t            state_r, state_s;
  logic [BEAT_W-1:0] ibeat_r, lo_r, hi_r;
  logic              loop_active_r, at_end_r;
  logic [W1-1:0]     cur_s, ns_s, lo_w_s, hi_w_s, beat_s, lo_s, hi_s;
  logic [W1-1:0]     fwd_next_s, seek_s, play_step_s, loop_step_s;
  logic              play_wrap_s, wrap_s, seek_ok_s, rev_s;

  function automatic logic [W1-1:0] note_start(input logic [W1-1:0] b);
    return b & ~(BPN_W - ONE_W);
  endfunction

  function automatic logic [W1-1:0] win_hi(input logic [W1-1:0] ns);
    logic [W1-1:0] top;
    top = ns + (BPN_W - ONE_W);
    return (top > LAST_W) ? LAST_W : top;
  endfunction

  function automatic logic [W1-1:0] win_lo(input logic [W1-1:0] ns);
    return (ns >= SPAN_W) ? (ns - SPAN_W) : ZERO_W;
  endfunction

`ifdef LOOP_PLAYER_REVERSE_EN
  assign rev_s = rev;
`else
  logic rev_unused_s;
  assign rev_unused_s = rev;
  assign rev_s        = 1'b0;
`endif

  assign cur_s      = {1'b0, ibeat_r};
  assign lo_w_s     = {1'b0, lo_r};
  assign hi_w_s     = {1'b0, hi_r};
  assign ns_s       = note_start(cur_s);
  assign seek_ok_s  = seek_fwd ^ seek_bwd;
  assign fwd_next_s = ns_s + BPN_W;
  // A forward seek past the last beat restarts the song without flagging a wrap.
  assign seek_s     = seek_fwd ? ((fwd_next_s >= LEN_W) ? ZERO_W : fwd_next_s)
                               : ((ns_s >= BPN_W) ? (ns_s - BPN_W) : ZERO_W);
  assign play_step_s = rev_s ? ((cur_s == ZERO_W) ? LAST_W : cur_s - ONE_W)
                             : ((cur_s == LAST_W) ? ZERO_W : cur_s + ONE_W);
  assign play_wrap_s = rev_s ? (cur_s == ZERO_W) : (cur_s == LAST_W);
  assign loop_step_s = rev_s ? ((cur_s == lo_w_s) ? hi_w_s : cur_s - ONE_W)
                             : ((cur_s == hi_w_s) ? lo_w_s : cur_s + ONE_W);

  // Next-state, next-beat and loop-window selection; stop beats seek beats tick.
  always_comb begin
    state_s = state_r;
    beat_s  = cur_s;
    lo_s    = lo_w_s;
    hi_s    = hi_w_s;
    wrap_s  = 1'b0;
    if (stop) begin
      state_s = IDLE;
      beat_s  = ZERO_W;
      lo_s    = ZERO_W;
      hi_s    = ZERO_W;
    end else begin
      case (state_r)
        IDLE: begin
          if (play) state_s = PLAY;
          else      state_s = IDLE;
        end
        PLAY: begin
          if (play && loop_en) begin
            state_s = LOOP;
            lo_s    = win_lo(ns_s);
            hi_s    = win_hi(ns_s);
          end else begin
            if (play) state_s = PLAY;
            else      state_s = PAUSE;
            if (seek_ok_s) begin
              beat_s = seek_s;
            end else if (tick) begin
              beat_s = play_step_s;
              wrap_s = play_wrap_s;
            end else begin
              beat_s = cur_s;
            end
          end
        end
        PAUSE: begin
          if (play) state_s = PLAY;
          else      state_s = PAUSE;
          if (seek_ok_s) beat_s = seek_s;
          else           beat_s = cur_s;
        end
        LOOP: begin
          if (tick) beat_s = loop_step_s;
          else      beat_s = cur_s;
          // Leaving the loop drops the window so the next entry latches a fresh one.
          if (!play) begin
            state_s = PAUSE;
            lo_s    = ZERO_W;
            hi_s    = ZERO_W;
          end else if (!loop_en) begin
            state_s = PLAY;
            lo_s    = ZERO_W;
            hi_s    = ZERO_W;
          end else begin
            state_s = LOOP;
          end
        end
        default: begin
          state_s = IDLE;
          beat_s  = ZERO_W;
          lo_s    = ZERO_W;
          hi_s    = ZERO_W;
        end
      endcase
    end
  end

  // State, beat, window and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      ibeat_r       <= {BEAT_W{1'b0}};
      lo_r          <= {BEAT_W{1'b0}};
      hi_r          <= {BEAT_W{1'b0}};
      loop_active_r <= 1'b0;
      at_end_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      ibeat_r       <= BEAT_W'(beat_s);
      lo_r          <= BEAT_W'(lo_s);
      hi_r          <= BEAT_W'(hi_s);
      loop_active_r <= (state_s == LOOP);
      at_end_r      <= wrap_s;
    end
  end

  assign ibeat       = ibeat_r;
  assign loop_active = loop_active_r;
  assign at_end      = at_end_r;

endmodule
